// File: rtl/regfile_writeback_ctrl.sv
// Register file write-back front end: ALU/MEM round-robin arbiter, result FIFO, write port.
// Optional forwarding lookup (chk_hit/chk_data) enabled by defining WB_FORWARD_EN.
module regfile_writeback_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   input  logic              wb_stall,
   input  logic              flush,
   output logic              reg_write_en,
   output logic [ADDR_W-1:0] reg_write_dest,
   output logic [DATA_W-1:0] reg_write_data,
   output logic              wb_busy,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              chk_hit,
   output logic [DATA_W-1:0] chk_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      PRIO_ALU = 1'b0,
      PRIO_MEM = 1'b1
   } prio_t;

   prio_t prio;

   logic [ADDR_W-1:0] q_dest [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              space;
   logic              alu_push;
   logic              mem_push;
   logic              push;
   logic              pop;
   logic              both_valid;
   logic [ADDR_W-1:0] push_dest;
   logic [DATA_W-1:0] push_data;

   // A pop in this cycle never frees space for a push in the same cycle
   assign space      = (count < CW'(DEPTH)) & ~flush;
   assign alu_ready  = space & (~mem_valid | (prio == PRIO_ALU));
   assign mem_ready  = space & (~alu_valid | (prio == PRIO_MEM));
   assign alu_push   = alu_valid & alu_ready;
   assign mem_push   = mem_valid & mem_ready;
   assign push       = alu_push | mem_push;
   assign pop        = (count != '0) & ~wb_stall & ~flush;
   assign both_valid = alu_valid & mem_valid;
   assign push_dest  = alu_push ? alu_dest : mem_dest;
   assign push_data  = alu_push ? alu_data : mem_data;
   assign wb_busy    = (count != '0) | reg_write_en;

   always_ff @(posedge clk) begin
      if (push) begin
         q_dest[wr_ptr] <= push_dest;
         q_data[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         prio           <= PRIO_ALU;
         reg_write_en   <= 1'b0;
         reg_write_dest <= '0;
         reg_write_data <= '0;
      end else begin
         if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            reg_write_en <= 1'b0;
         end else begin
            reg_write_en <= pop;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
               rd_ptr         <= rd_ptr + PW'(1);
               reg_write_dest <= q_dest[rd_ptr];
               reg_write_data <= q_data[rd_ptr];
            end
            unique case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
         // Hand priority to the producer that lost this contention
         if (both_valid & push) begin
            prio <= (prio == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;
         end
      end
   end

`ifdef WB_FORWARD_EN
   logic [PW-1:0] fwd_idx;

   // Walk oldest to youngest so the youngest match overrides
   always_comb begin
      fwd_idx  = '0;
      chk_hit  = reg_write_en & (reg_write_dest == chk_addr);
      chk_data = chk_hit ? reg_write_data : '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr + PW'(i);
         if ((CW'(i) < count) && (q_dest[fwd_idx] == chk_addr)) begin
            chk_hit  = 1'b1;
            chk_data = q_data[fwd_idx];
         end
      end
   end
`else
   logic chk_unused;

   assign chk_unused = ^chk_addr;
   assign chk_hit    = 1'b0;
   assign chk_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: vector table plus scoreboard of pending writes.
// Reset, arbitration, full/stall, flush, forwarding and async reset mid-drain.
module tb_regfile_writeback_ctrl;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [3:0]  alu_dest;
   logic [15:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [3:0]  mem_dest;
   logic [15:0] mem_data;
   logic        mem_ready;
   logic        wb_stall;
   logic        flush;
   logic        reg_write_en;
   logic [3:0]  reg_write_dest;
   logic [15:0] reg_write_data;
   logic        wb_busy;
   logic [3:0]  chk_addr;
   logic        chk_hit;
   logic [15:0] chk_data;

   regfile_writeback_ctrl #(
      .DATA_W(16),
      .ADDR_W(4),
      .DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid     (alu_valid),
      .alu_dest      (alu_dest),
      .alu_data      (alu_data),
      .alu_ready     (alu_ready),
      .mem_valid     (mem_valid),
      .mem_dest      (mem_dest),
      .mem_data      (mem_data),
      .mem_ready     (mem_ready),
      .wb_stall      (wb_stall),
      .flush         (flush),
      .reg_write_en  (reg_write_en),
      .reg_write_dest(reg_write_dest),
      .reg_write_data(reg_write_data),
      .wb_busy       (wb_busy),
      .chk_addr      (chk_addr),
      .chk_hit       (chk_hit),
      .chk_data      (chk_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [3:0]  ad;
      logic [15:0] ax;
      logic        mv;
      logic [3:0]  md;
      logic [15:0] mx;
      logic        st;
      logic        fl;
      logic [3:0]  ca;
      logic        ea;
      logic        em;
   } vec_t;

   typedef struct {
      logic [3:0]  d;
      logic [15:0] x;
   } ent_t;

   localparam int NV = 34;

   vec_t        vt [NV];
   ent_t        sb [$];
   logic        m_prio;
   logic        m_en;
   logic [3:0]  m_dest;
   logic [15:0] m_data;
   int          n_tests;
   int          n_fail;

   function automatic vec_t mk(
      logic av, logic [3:0] ad, logic [15:0] ax,
      logic mv, logic [3:0] md, logic [15:0] mx,
      logic st, logic fl, logic [3:0] ca,
      logic ea, logic em);
      vec_t v;
      v.av = av; v.ad = ad; v.ax = ax;
      v.mv = mv; v.md = md; v.mx = mx;
      v.st = st; v.fl = fl; v.ca = ca;
      v.ea = ea; v.em = em;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic drive(vec_t v);
      alu_valid = v.av;
      alu_dest  = v.ad;
      alu_data  = v.ax;
      mem_valid = v.mv;
      mem_dest  = v.md;
      mem_data  = v.mx;
      wb_stall  = v.st;
      flush     = v.fl;
      chk_addr  = v.ca;
   endtask

   task automatic model_rdy(output logic ar, output logic mr);
      logic sp;
      sp = (sb.size() < 4) && !flush;
      ar = sp && (!mem_valid || m_prio == 1'b0);
      mr = sp && (!alu_valid || m_prio == 1'b1);
   endtask

   task automatic model_reset();
      sb.delete();
      m_prio = 1'b0;
      m_en   = 1'b0;
      m_dest = '0;
      m_data = '0;
   endtask

   task automatic check_fwd(string tag);
      logic        h;
      logic [15:0] d;
      h = 1'b0;
      d = '0;
`ifdef WB_FORWARD_EN
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (!h && sb[i].d == chk_addr) begin
            h = 1'b1;
            d = sb[i].x;
         end
      end
      if (!h && m_en && m_dest == chk_addr) begin
         h = 1'b1;
         d = m_data;
      end
`endif
      check({tag, " chk_hit"}, 32'(chk_hit), 32'(h));
      if (h) check({tag, " chk_data"}, 32'(chk_data), 32'(d));
   endtask

   // Entered just after a negedge with inputs applied; returns at next negedge
   task automatic cycle(string tag, logic ea, logic em);
      logic ar;
      logic mr;
      logic acc_a;
      logic acc_m;
      logic pop;
      #1;
      check({tag, " alu_ready"}, 32'(alu_ready), 32'(ea));
      check({tag, " mem_ready"}, 32'(mem_ready), 32'(em));
      check_fwd(tag);
      @(posedge clk);
      model_rdy(ar, mr);
      acc_a = alu_valid && ar;
      acc_m = mem_valid && mr;
      pop   = (sb.size() > 0) && !wb_stall && !flush;
      if (pop) begin
         m_en   = 1'b1;
         m_dest = sb[0].d;
         m_data = sb[0].x;
         void'(sb.pop_front());
      end else begin
         m_en = 1'b0;
      end
      if (flush) sb.delete();
      if (acc_a) sb.push_back('{alu_dest, alu_data});
      else if (acc_m) sb.push_back('{mem_dest, mem_data});
      if (alu_valid && mem_valid && (acc_a || acc_m)) m_prio = !m_prio;
      #1;
      check({tag, " wr_en"}, 32'(reg_write_en), 32'(m_en));
      check({tag, " wr_dest"}, 32'(reg_write_dest), 32'(m_dest));
      check({tag, " wr_data"}, 32'(reg_write_data), 32'(m_data));
      check({tag, " wb_busy"}, 32'(wb_busy),
            32'((sb.size() != 0) || m_en));
      @(negedge clk);
   endtask

   task automatic model_cycle(string tag);
      logic ar;
      logic mr;
      model_rdy(ar, mr);
      cycle(tag, ar, mr);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();

      vt[0]  = mk(1, 4'd3, 16'h1234, 0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 0);
      vt[1]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 1);
      vt[2]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd3, 1, 1);
      vt[3]  = mk(1, 4'd1, 16'h0011, 1, 4'd2, 16'h0022, 0, 0, 4'd1, 1, 0);
      vt[4]  = mk(1, 4'd1, 16'h0111, 1, 4'd2, 16'h0022, 0, 0, 4'd2, 0, 1);
      vt[5]  = mk(1, 4'd1, 16'h0111, 1, 4'd2, 16'h0222, 0, 0, 4'd1, 1, 0);
      vt[6]  = mk(1, 4'd1, 16'h1111, 1, 4'd2, 16'h0222, 0, 0, 4'd2, 0, 1);
      vt[7]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd2, 1, 1);
      vt[8]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 1);
      vt[9]  = mk(1, 4'd4, 16'h4000, 0, 4'd0, 16'h0000, 1, 0, 4'd4, 1, 0);
      vt[10] = mk(1, 4'd5, 16'h4001, 0, 4'd0, 16'h0000, 1, 0, 4'd4, 1, 0);
      vt[11] = mk(1, 4'd6, 16'h4002, 0, 4'd0, 16'h0000, 1, 0, 4'd6, 1, 0);
      vt[12] = mk(1, 4'd7, 16'h4003, 0, 4'd0, 16'h0000, 1, 0, 4'd7, 1, 0);
      vt[13] = mk(1, 4'd8, 16'h4004, 0, 4'd0, 16'h0000, 1, 0, 4'd8, 0, 0);
      vt[14] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd5, 0, 0);
      vt[15] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd4, 1, 1);
      vt[16] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 1);
      vt[17] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd7, 1, 1);
      vt[18] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd7, 1, 1);
      vt[19] = mk(0, 4'd0, 16'h0000, 1, 4'd0, 16'haaa0, 1, 0, 4'd0, 1, 1);
      vt[20] = mk(0, 4'd0, 16'h0000, 1, 4'd0, 16'haaa1, 1, 0, 4'd0, 1, 1);
      vt[21] = mk(0, 4'd0, 16'h0000, 1, 4'd9, 16'haaa2, 1, 0, 4'd0, 1, 1);
      vt[22] = mk(0, 4'd0, 16'h0000, 1, 4'd9, 16'hbad0, 0, 1, 4'd9, 0, 0);
      vt[23] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 1);
      vt[24] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd9, 1, 1);
      vt[25] = mk(0, 4'd0, 16'h0000, 1, 4'd0, 16'hbeef, 0, 0, 4'd0, 1, 1);
      vt[26] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 1);
      vt[27] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd0, 1, 1);
      vt[28] = mk(1, 4'd5, 16'h0001, 0, 4'd0, 16'h0000, 1, 0, 4'd5, 1, 0);
      vt[29] = mk(1, 4'd5, 16'h0002, 0, 4'd0, 16'h0000, 1, 0, 4'd5, 1, 0);
      vt[30] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 4'd5, 1, 1);
      vt[31] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd5, 1, 1);
      vt[32] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd5, 1, 1);
      vt[33] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'd5, 1, 1);

      rst_n = 1'b0;
      drive(mk(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 0, 0));
      #1;
      check("reset wr_en", 32'(reg_write_en), 32'd0);
      check("reset wr_dest", 32'(reg_write_dest), 32'd0);
      check("reset wr_data", 32'(reg_write_data), 32'd0);
      check("reset wb_busy", 32'(wb_busy), 32'd0);
      check("reset chk_hit", 32'(chk_hit), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         cycle($sformatf("vec%0d", i), vt[i].ea, vt[i].em);
      end

      // Asynchronous reset in the middle of a drain
      drive(mk(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 0, 4'd7, 0, 0));
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1;
         alu_dest  = 4'(7 + i);
         alu_data  = 16'h7000 + 16'(i);
         model_cycle($sformatf("rq%0d", i));
      end
      alu_valid = 1'b0;
      wb_stall  = 1'b0;
      model_cycle("rdrain");
      check("rdrain pulse", 32'(reg_write_en), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst wr_en", 32'(reg_write_en), 32'd0);
      check("rst wb_busy", 32'(wb_busy), 32'd0);
      check("rst wr_dest", 32'(reg_write_dest), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         model_cycle($sformatf("rpost%0d", i));
      end

      // Short random burst against the model
      for (int i = 0; i < 60; i++) begin
         alu_valid = 1'($urandom_range(0, 1));
         alu_dest  = 4'($urandom_range(0, 15));
         alu_data  = 16'($urandom);
         mem_valid = 1'($urandom_range(0, 1));
         mem_dest  = 4'($urandom_range(0, 15));
         mem_data  = 16'($urandom);
         wb_stall  = ($urandom_range(0, 3) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         chk_addr  = 4'($urandom_range(0, 15));
         model_cycle($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
